soc_system_button_debounce: RTL and testbench

//   Conditions the raw DE1-SoC KEY inputs before they reach the button PIO's in_port.
//   - Synchronises each asynchronous key input into the clk domain.
//   - Debounces each bit independently.
//   - Normalises the keys to active-high "pressed".
//   - Emits a one-cycle press strobe per key for local logic.

---
 rtl/soc_system_button_debounce.sv | 74 +++++++
 tb/tb_soc_system_button_debounce.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/soc_system_button_debounce.sv
// soc_system_button_debounce: sync, debounce and normalise raw KEY inputs, with per-key press strobes.
// Optional macro BUTTON_DEBOUNCE_RELEASE_PULSE_EN adds the release_pulse output.
`default_nettype none

module soc_system_button_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] button_db,
  output logic [WIDTH-1:0] press_pulse
`ifdef BUTTON_DEBOUNCE_RELEASE_PULSE_EN
  ,
  output logic [WIDTH-1:0] release_pulse
`endif
);

  localparam logic [WIDTH-1:0] IDLE    = {WIDTH{ACTIVE_LOW}};
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] db_nxt;
  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];

  assign s = ACTIVE_LOW ? ~sync2 : sync2;

  // Any sample matching the accepted level restarts that key's count.
  always_comb begin
    cnt_nxt = cnt;
    db_nxt  = button_db;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] == button_db[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] < CNT_MAX) begin
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end else begin
        cnt_nxt[i] = '0;
        db_nxt[i]  = s[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1       <= IDLE;
      sync2       <= IDLE;
      cnt         <= '{default: '0};
      button_db   <= '0;
      press_pulse <= '0;
`ifdef BUTTON_DEBOUNCE_RELEASE_PULSE_EN
      release_pulse <= '0;
`endif
    end else begin
      sync1       <= key_raw;
      sync2       <= sync1;
      cnt         <= cnt_nxt;
      button_db   <= db_nxt;
      press_pulse <= db_nxt & ~button_db;
`ifdef BUTTON_DEBOUNCE_RELEASE_PULSE_EN
      release_pulse <= ~db_nxt & button_db;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_soc_system_button_debounce.sv
// Directed self-checking bench for soc_system_button_debounce (DEBOUNCE_CYCLES=8, CNT_W=4, ACTIVE_LOW=1).
`default_nettype none

module tb_soc_system_button_debounce;

  logic       clk;
  logic       reset_n;
  logic [3:0] key_raw;
  logic [3:0] button_db;
  logic [3:0] press_pulse;
`ifdef BUTTON_DEBOUNCE_RELEASE_PULSE_EN
  logic [3:0] release_pulse;
`endif

  int checks   = 0;
  int failures = 0;

  soc_system_button_debounce #(
    .WIDTH(4), .DEBOUNCE_CYCLES(8), .CNT_W(4), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .key_raw(key_raw),
    .button_db(button_db),
    .press_pulse(press_pulse)
`ifdef BUTTON_DEBOUNCE_RELEASE_PULSE_EN
    ,
    .release_pulse(release_pulse)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset with keys idle, then quiet operation
    reset_n = 1'b0;
    key_raw = 4'hF;
    repeat (3) tick();
    chk("rst_db", button_db, 4'h0);
    chk("rst_pp", press_pulse, 4'h0);
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("idle_db_pp", {button_db, press_pulse}, 8'h00);
    end

    // 2: clean press of key 0, accepted on edge 10
    key_raw = 4'hE;
    repeat (9) tick();
    chk("k0_db_e9", button_db, 4'h0);
    chk("k0_pp_e9", press_pulse, 4'h0);
    tick();
    chk("k0_db_e10", button_db, 4'h1);
    chk("k0_pp_e10", press_pulse, 4'h1);
    tick();
    chk("k0_db_e11", button_db, 4'h1);
    chk("k0_pp_e11", press_pulse, 4'h0);

    // 3: key 1 bounces every 3 cycles, never stable long enough
    for (int c = 0; c < 40; c++) begin
      if (c % 3 == 0) key_raw[1] = ~key_raw[1];
      tick();
      chk("bounce_db1", button_db[1], 1'b0);
    end
    key_raw[1] = 1'b0;
    repeat (9) tick();
    chk("k1_db_e9", button_db, 4'h1);
    tick();
    chk("k1_db_e10", button_db, 4'h3);
    chk("k1_pp_e10", press_pulse, 4'h2);

    // 4: keys 2 and 3 together
    key_raw = 4'h0;
    repeat (9) tick();
    chk("k23_db_e9", button_db, 4'h3);
    tick();
    chk("k23_db_e10", button_db, 4'hF);
    chk("k23_pp_e10", press_pulse, 4'hC);
    tick();
    chk("k23_pp_e11", press_pulse, 4'h0);

    // 5: reset mid-count discards partial progress
    reset_n = 1'b0;
    key_raw = 4'hF;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("r5_db_idle", button_db, 4'h0);
    key_raw = 4'hE;
    repeat (7) tick();
    reset_n = 1'b0;
    tick();
    chk("r5_db_rst", button_db, 4'h0);
    chk("r5_pp_rst", press_pulse, 4'h0);
    reset_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("r5_db_wait", {button_db, press_pulse}, 8'h00);
    end
    tick();
    chk("r5_db_e10", button_db, 4'h1);
    chk("r5_pp_e10", press_pulse, 4'h1);

`ifdef BUTTON_DEBOUNCE_RELEASE_PULSE_EN
    // 6: release of key 0
    tick();
    chk("rel_idle", release_pulse, 4'h0);
    key_raw = 4'hF;
    repeat (9) tick();
    chk("rel_db_e9", button_db, 4'h1);
    chk("rel_rp_e9", release_pulse, 4'h0);
    tick();
    chk("rel_db_e10", button_db, 4'h0);
    chk("rel_rp_e10", release_pulse, 4'h1);
    chk("rel_pp_e10", press_pulse, 4'h0);
    tick();
    chk("rel_rp_e11", release_pulse, 4'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
